fp_div_seq: RTL and testbench

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_div_seq.sv | 201 ++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_div_seq: sequential IEEE-754 single-precision divider (restoring,     |
// | 26 quotient bits, flush-to-zero). FP_DIV_ROUND_NEAREST_EN selects RNE.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] floatA,
    input  logic [31:0] floatB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] outFloat,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;
    localparam logic [30:0] C_INF  = 31'h7F80_0000;
`ifdef FP_DIV_ROUND_NEAREST_EN
    localparam logic        C_RNE  = 1'b1;
`else
    localparam logic        C_RNE  = 1'b0;
`endif

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_q, out_d;
    logic               dz_q, dz_d;
    logic               sign_q, sign_d;
    logic [23:0]        mb_q, mb_d;
    logic [25:0]        rem_q, rem_d;
    logic [25:0]        quo_q, quo_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [4:0]         cnt_q, cnt_d;

    // Operand classification; exp==0 counts as zero so subnormals never reach DIV.
    logic [7:0]  w_exp_a, w_exp_b;
    logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b, w_sign;
    logic        w_special, w_special_dz;
    logic [31:0] w_special_res;

    assign w_exp_a  = floatA[30:23];
    assign w_exp_b  = floatB[30:23];
    assign w_nan_a  = (w_exp_a == 8'hFF) && (floatA[22:0] != 23'd0);
    assign w_nan_b  = (w_exp_b == 8'hFF) && (floatB[22:0] != 23'd0);
    assign w_inf_a  = (w_exp_a == 8'hFF) && (floatA[22:0] == 23'd0);
    assign w_inf_b  = (w_exp_b == 8'hFF) && (floatB[22:0] == 23'd0);
    assign w_zero_a = (w_exp_a == 8'h00);
    assign w_zero_b = (w_exp_b == 8'h00);
    assign w_sign   = floatA[31] ^ floatB[31];
    assign w_special = w_nan_a | w_nan_b | w_inf_a | w_inf_b | w_zero_a | w_zero_b;

    always_comb begin
        w_special_res = {w_sign, 31'd0};
        w_special_dz  = 1'b0;
        if (w_nan_a || w_nan_b || (w_zero_a && w_zero_b) || (w_inf_a && w_inf_b)) begin
            w_special_res = C_QNAN;
        end else if (w_zero_b) begin
            w_special_res = {w_sign, C_INF};
            w_special_dz  = 1'b1;
        end else if (w_inf_a) begin
            w_special_res = {w_sign, C_INF};
        end
    end

    // One restoring step: remainder is kept pre-shifted for the next compare.
    logic        w_ge;
    logic [25:0] w_rem_next;
    assign w_ge       = (rem_q >= {2'b00, mb_q});
    assign w_rem_next = w_ge ? (rem_q - {2'b00, mb_q}) : rem_q;

    logic [22:0]       w_mant;
    logic              w_guard, w_sticky, w_inc;
    logic [23:0]       w_mant_rnd;
    logic signed [9:0] w_exp_n, w_exp_r;
    logic [31:0]       w_result;

    always_comb begin
        if (quo_q[25]) begin
            w_mant   = quo_q[24:2];
            w_guard  = quo_q[1];
            w_sticky = quo_q[0] | (rem_q != 26'd0);
            w_exp_n  = exp_q;
        end else begin
            w_mant   = quo_q[23:1];
            w_guard  = quo_q[0];
            w_sticky = (rem_q != 26'd0);
            w_exp_n  = exp_q - 10'sd1;
        end
        w_inc      = C_RNE & w_guard & (w_sticky | w_mant[0]);
        w_mant_rnd = {1'b0, w_mant} + {23'd0, w_inc};
        w_exp_r    = w_mant_rnd[23] ? (w_exp_n + 10'sd1) : w_exp_n;
        if (w_exp_r >= 10'sd255) begin
            w_result = {sign_q, C_INF};
        end else if (w_exp_r <= 10'sd0) begin
            w_result = {sign_q, 31'd0};
        end else begin
            w_result = {sign_q, w_exp_r[7:0], w_mant_rnd[22:0]};
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        dz_d        = dz_q;
        sign_d      = sign_q;
        mb_d        = mb_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d = w_sign;
                    mb_d   = {1'b1, floatB[22:0]};
                    rem_d  = {3'b001, floatA[22:0]};
                    quo_d  = 26'd0;
                    cnt_d  = 5'd0;
                    exp_d  = $signed({2'b00, w_exp_a}) - $signed({2'b00, w_exp_b}) + 10'sd127;
                    if (w_special) begin
                        out_d       = w_special_res;
                        dz_d        = w_special_dz;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                quo_d = {quo_q[24:0], w_ge};
                rem_d = w_rem_next << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                out_d       = w_result;
                dz_d        = 1'b0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= 32'd0;
            dz_q        <= 1'b0;
            sign_q      <= 1'b0;
            mb_q        <= 24'd0;
            rem_q       <= 26'd0;
            quo_q       <= 26'd0;
            exp_q       <= 10'sd0;
            cnt_q       <= 5'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            dz_q        <= dz_d;
            sign_q      <= sign_d;
            mb_q        <= mb_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            exp_q       <= exp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign outFloat    = out_q;
    assign div_by_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp_div_seq: directed self-checking bench for fp_div_seq.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fp_div_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] floatA;
    logic [31:0] floatB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] outFloat;
    logic        div_by_zero;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    fp_div_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .floatA     (floatA),
        .floatB     (floatB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .outFloat   (outFloat),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation; lat is the cycle index (1 = cycle after the accept edge)
    // at which out_valid is first seen. Operands are corrupted while busy.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int stall, output int lat,
                          output logic [31:0] res, output logic dz);
        int w;
        lat = 0;
        @(negedge clk);
        floatA   = a;
        floatB   = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        floatA = 32'hFFFF_FFFF;
        floatB = 32'h3F80_0000;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        in_valid = 1'b0;
        res = outFloat;
        dz  = div_by_zero;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, " stall outFloat"}, outFloat, res);
            check({tag, " stall out_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, " stall in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, " post out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " post in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    int          lat;
    logic [31:0] res;
    logic        dz;
    logic [31:0] third_exp;
    bit          seen;

    initial begin
`ifdef FP_DIV_ROUND_NEAREST_EN
        third_exp = 32'h3EAA_AAAB;
`else
        third_exp = 32'h3EAA_AAAA;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        floatA    = 32'd0;
        floatB    = 32'd0;
        repeat (3) @(negedge clk);
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset outFloat", outFloat, 32'd0);
        check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);

        run_op("6/2", 32'h40C0_0000, 32'h4000_0000, 0, lat, res, dz);
        check("6/2 latency", lat, 32'd28);
        check("6/2 result", res, 32'h4040_0000);
        check("6/2 dz", {31'd0, dz}, 32'd0);

        run_op("1/3", 32'h3F80_0000, 32'h4040_0000, 5, lat, res, dz);
        check("1/3 latency", lat, 32'd28);
        check("1/3 result", res, third_exp);

        run_op("-2/0", 32'hC000_0000, 32'h0000_0000, 0, lat, res, dz);
        check("-2/0 latency", lat, 32'd1);
        check("-2/0 result", res, 32'hFF80_0000);
        check("-2/0 dz", {31'd0, dz}, 32'd1);

        run_op("0/0", 32'h0000_0000, 32'h0000_0000, 0, lat, res, dz);
        check("0/0 latency", lat, 32'd1);
        check("0/0 result", res, 32'h7FC0_0000);
        check("0/0 dz", {31'd0, dz}, 32'd0);

        run_op("ovf", 32'h7F00_0000, 32'h3E80_0000, 0, lat, res, dz);
        check("ovf latency", lat, 32'd28);
        check("ovf result", res, 32'h7F80_0000);

        run_op("unf", 32'h0080_0000, 32'h4000_0000, 0, lat, res, dz);
        check("unf latency", lat, 32'd28);
        check("unf result", res, 32'h0000_0000);

        // Abort a division with reset ten cycles after it was accepted.
        @(negedge clk);
        floatA   = 32'h40C0_0000;
        floatB   = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst outFloat", outFloat, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst no result", {31'd0, seen}, 32'd0);
        check("midrst in_ready idle", {31'd0, in_ready}, 32'd1);

        run_op("10/5", 32'h4120_0000, 32'h40A0_0000, 0, lat, res, dz);
        check("10/5 latency", lat, 32'd28);
        check("10/5 result", res, 32'h4000_0000);
        check("10/5 dz", {31'd0, dz}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
